// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition block: state encoding and the
// fixed-point scaling exponent used to map the averaged code onto the output.
package adc_acq_pkg;

  // Acquisition states, encoded as reported on ACQ_STATE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } acq_state_e;

  // Base left-shift that places a full-scale raw code at +/-1.0 in the
  // fixed-point output; the averaging exponent L is subtracted from it.
  function automatic int fp_scale_base(input int fp_w, input int int_w, input int raw_w);
    return fp_w - int_w - (raw_w - 1);
  endfunction

endpackage

// File: rtl/adc_acq.sv
// ADC acquisition: optional settle period, then 2^L sample accumulation,
// result scaled to signed fixed-point and held until the request drops.
// Optional feature: define ADC_ACQ_OFFSET_EN to add an OFFSET port that is
// subtracted from every accumulated sample (clip detection stays on raw codes).
module adc_acq
  import adc_acq_pkg::*;
#(
  parameter int FP_WIDTH     = 32,
  parameter int INT_WIDTH    = 16,
  parameter int RAW_WIDTH    = 14,
  parameter int MAX_LOG2_AVG = 8
) (
  input  logic                        ADC_CLK,
  input  logic                        RST,
  input  logic signed [RAW_WIDTH-1:0] ADC_RAW,
`ifdef ADC_ACQ_OFFSET_EN
  input  logic signed [RAW_WIDTH-1:0] OFFSET,
`endif
  input  logic                        ADC_EN,
  input  logic [31:0]                 SETTLE,
  input  logic [3:0]                  LOG2_AVG,
  output logic                        ADC_DONE,
  output logic [FP_WIDTH-1:0]         ADC_OUT,
  output logic                        CLIP,
  output logic [1:0]                  ACQ_STATE
);

  localparam int ACC_W      = RAW_WIDTH + MAX_LOG2_AVG + 1;
  localparam int CNT_W      = MAX_LOG2_AVG + 1;
  localparam int SCALE_BASE = fp_scale_base(FP_WIDTH, INT_WIDTH, RAW_WIDTH);
  localparam int WIDE_W     = ACC_W + FP_WIDTH + MAX_LOG2_AVG + 2;

  localparam logic signed [RAW_WIDTH-1:0] RAW_MAX = {1'b0, {(RAW_WIDTH-1){1'b1}}};
  localparam logic signed [RAW_WIDTH-1:0] RAW_MIN = {1'b1, {(RAW_WIDTH-1){1'b0}}};
  localparam logic [3:0] L_CAP = (MAX_LOG2_AVG > 15) ? 4'd15 : 4'(MAX_LOG2_AVG);

  acq_state_e                state_q, state_d;
  logic [31:0]               settle_q, settle_d;
  logic [3:0]                l_q, l_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [FP_WIDTH-1:0]       out_q, out_d;
  logic                      done_q, done_d;
  logic                      clip_q, clip_d;

  logic signed [RAW_WIDTH:0] sample_s;
  logic signed [ACC_W-1:0]   sample_ext_s;
  logic                      raw_clip_s;
  logic                      cnt_last_s;
  logic signed [WIDE_W-1:0]  acc_wide_s;
  logic signed [WIDE_W-1:0]  scaled_s;
  int                        exp_s;

`ifdef ADC_ACQ_OFFSET_EN
  assign sample_s = {ADC_RAW[RAW_WIDTH-1], ADC_RAW} - {OFFSET[RAW_WIDTH-1], OFFSET};
`else
  assign sample_s = {ADC_RAW[RAW_WIDTH-1], ADC_RAW};
`endif

  assign sample_ext_s = {{(ACC_W-RAW_WIDTH-1){sample_s[RAW_WIDTH]}}, sample_s};
  assign raw_clip_s   = (ADC_RAW == RAW_MAX) || (ADC_RAW == RAW_MIN);
  assign cnt_last_s   = (cnt_q == (CNT_W'(1) << l_q));
  assign acc_wide_s   = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};

  // Scale the accumulator by 2^(SCALE_BASE-L): left or arithmetic right shift.
  always_comb begin
    exp_s = SCALE_BASE - int'(l_q);
    if (exp_s >= 0) begin
      scaled_s = acc_wide_s <<< exp_s;
    end else begin
      scaled_s = acc_wide_s >>> (-exp_s);
    end
  end

  // Next-state and datapath updates for the acquisition sequence.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    l_d      = l_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    out_d    = out_q;
    done_d   = done_q;
    clip_d   = clip_q;
    case (state_q)
      ST_IDLE: begin
        if (ADC_EN) begin
          settle_d = SETTLE;
          l_d      = (LOG2_AVG > L_CAP) ? L_CAP : LOG2_AVG;
          cnt_d    = '0;
          acc_d    = '0;
          clip_d   = 1'b0;
          state_d  = (SETTLE != 32'd0) ? ST_SETTLE : ST_ACCUM;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!ADC_EN) begin
          state_d  = ST_IDLE;
        end else if (settle_q <= 32'd1) begin
          state_d  = ST_ACCUM;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      ST_ACCUM: begin
        if (!ADC_EN) begin
          state_d = ST_IDLE;
        end else if (cnt_last_s) begin
          out_d   = scaled_s[FP_WIDTH-1:0];
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_d   = acc_q + sample_ext_s;
          cnt_d   = cnt_q + CNT_W'(1);
          clip_d  = clip_q | raw_clip_s;
        end
      end
      ST_DONE: begin
        if (!ADC_EN) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by RST.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      settle_q <= 32'd0;
      l_q      <= 4'd0;
      cnt_q    <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      l_q      <= l_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      done_q   <= done_d;
      clip_q   <= clip_d;
    end
  end

  assign ADC_DONE  = done_q;
  assign ADC_OUT   = out_q;
  assign CLIP      = clip_q;
  assign ACQ_STATE = state_q;

endmodule
